// File: rtl/m_seq_pkg.sv
// m_seq_pkg: shared constants and the LFSR feedback helper for the
// 63-chip m-sequence generator (m_seq63) and its serializer (imp_200).
package m_seq_pkg;

  localparam int          SEQ_LEN      = 63;   // chips per period
  localparam int          REG_W        = 70;   // width of history / snapshot regs
  localparam int          LFSR_W       = 6;    // LFSR state width
  localparam logic [5:0]  SEED         = 6'b111111;
  localparam int          TAP_A        = 5;    // x^6 term
  localparam int          TAP_B        = 4;    // x^5 term
  localparam int          CHIP_LEN_DEF = 200;  // imp_200 cycles per chip

  // Last value of the period counter and first chip index of a frame.
  localparam logic [LFSR_W-1:0] CNT_MAX   = LFSR_W'(SEQ_LEN - 1);
  localparam logic [LFSR_W-1:0] IDX_START = LFSR_W'(SEQ_LEN - 1);

  // Fibonacci step for x^6 + x^5 + 1: shift left, feed back s[5]^s[4].
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
    return {s[LFSR_W-2:0], s[TAP_A] ^ s[TAP_B]};
  endfunction

endpackage

// File: rtl/imp_200.sv
// imp_200: serializes a 63-chip frame MSB first, each chip held for
// CHIP_LEN cycles, repeating forever. The frame is latched at frame start
// so input changes only take effect on the following frame.
// Ports:
//   clk        - clock, rising edge
//   reset      - synchronous active-low reset
//   m_seq_reg2 - frame source, bits 62:0 used
//   out_imp    - registered serial output
module imp_200
  import m_seq_pkg::*;
#(
  parameter int CHIP_LEN = CHIP_LEN_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] m_seq_reg2,
  output logic             out_imp
);

  localparam int SUB_W = (CHIP_LEN > 1) ? $clog2(CHIP_LEN) : 1;
  localparam logic [SUB_W-1:0] SUB_MAX = SUB_W'(CHIP_LEN - 1);

  logic [SUB_W-1:0]   sub_d;
  logic [SUB_W-1:0]   sub_q;
  logic [LFSR_W-1:0]  idx_d;
  logic [LFSR_W-1:0]  idx_q;
  logic [SEQ_LEN-1:0] frame_d;
  logic [SEQ_LEN-1:0] frame_q;
  logic               out_d;
  logic               out_q;
  logic               frame_start;
  logic [SEQ_LEN-1:0] cur_frame;
  logic               unused_hi;

  assign unused_hi = ^m_seq_reg2[REG_W-1:SEQ_LEN];

  always_comb begin
    frame_d     = frame_q;
    sub_d       = sub_q + 1'b1;
    idx_d       = idx_q;
    frame_start = (idx_q == IDX_START) && (sub_q == '0);
    // At frame start the first chip comes straight from the input, since
    // the frame register is being loaded on the same edge.
    cur_frame   = frame_start ? m_seq_reg2[SEQ_LEN-1:0] : frame_q;
    out_d       = cur_frame[idx_q];
    if (frame_start) begin
      frame_d = m_seq_reg2[SEQ_LEN-1:0];
    end
    if (sub_q == SUB_MAX) begin
      sub_d = '0;
      idx_d = (idx_q == '0) ? IDX_START : idx_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      sub_q   <= '0;
      idx_q   <= IDX_START;
      frame_q <= '0;
      out_q   <= 1'b0;
    end else begin
      sub_q   <= sub_d;
      idx_q   <= idx_d;
      frame_q <= frame_d;
      out_q   <= out_d;
    end
  end

  assign out_imp = out_q;

endmodule

// File: rtl/m_seq63_lfsr6.sv
// lfsr6: 6-bit Fibonacci LFSR state register, seeded with all ones.
// Ports:
//   clk    - clock, rising edge
//   rst_n  - synchronous active-low reset (loads SEED)
//   status - current LFSR state
module lfsr6
  import m_seq_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  output logic [LFSR_W-1:0] status
);

  logic [LFSR_W-1:0] status_d;
  logic [LFSR_W-1:0] status_q;

  always_comb begin
    status_d = lfsr_next(status_q);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      status_q <= SEED;
    end else begin
      status_q <= status_d;
    end
  end

  assign status = status_q;

endmodule

// File: rtl/m_seq63.sv
// m_seq63: 63-chip maximal-length sequence generator (x^6 + x^5 + 1).
// Ports:
//   sclk       - clock, rising edge
//   rst_n      - synchronous active-low reset
//   m_seq      - current chip (LFSR state bit 5, straight from the register)
//   status     - current LFSR state
//   m_seq_reg  - chip history, newest chip at bit 0
//   m_seq_reg2 - snapshot of the last full period, oldest chip at bit 62,
//                bits 69:63 always zero
module m_seq63
  import m_seq_pkg::*;
(
  input  logic              sclk,
  input  logic              rst_n,
  output logic              m_seq,
  output logic [LFSR_W-1:0] status,
  output logic [REG_W-1:0]  m_seq_reg,
  output logic [REG_W-1:0]  m_seq_reg2
);

  logic [LFSR_W-1:0] cnt_d;
  logic [LFSR_W-1:0] cnt_q;
  logic [REG_W-1:0]  hist_d;
  logic [REG_W-1:0]  hist_q;
  logic [REG_W-1:0]  snap_d;
  logic [REG_W-1:0]  snap_q;

  lfsr6 u_lfsr6 (
    .clk    (sclk),
    .rst_n  (rst_n),
    .status (status)
  );

  assign m_seq = status[LFSR_W-1];

  always_comb begin
    cnt_d  = (cnt_q == CNT_MAX) ? '0 : cnt_q + 1'b1;
    hist_d = {hist_q[REG_W-2:0], m_seq};
    snap_d = snap_q;
    // The load takes the 62 previous chips plus the current one, so the
    // snapshot matches what the history register holds after this edge.
    if (cnt_q == CNT_MAX) begin
      snap_d = {7'b0, hist_q[SEQ_LEN-2:0], m_seq};
    end
  end

  always_ff @(posedge sclk) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      hist_q <= '0;
      snap_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      hist_q <= hist_d;
      snap_q <= snap_d;
    end
  end

  assign m_seq_reg  = hist_q;
  assign m_seq_reg2 = snap_q;

endmodule

// File: tb/tb_m_seq63.sv
// tb_m_seq63: directed checks of m_seq63 and imp_200 (CHIP_LEN = 4).
module tb_m_seq63;
  import m_seq_pkg::*;

  logic              sclk = 1'b0;
  logic              rst_n;
  logic              imp_rst_n;
  logic              m_seq;
  logic [5:0]        status;
  logic [69:0]       m_seq_reg;
  logic [69:0]       m_seq_reg2;
  logic [69:0]       imp_in;
  logic              out_imp;

  int n_checks = 0;
  int n_err    = 0;

  logic [5:0]  exp_state [0:63];
  logic        exp_chip  [0:62];
  logic [62:0] exp_frame;
  logic [62:0] ones63;
  logic [62:0] one63;
  logic [63:0] seen;

  m_seq63 dut (
    .sclk       (sclk),
    .rst_n      (rst_n),
    .m_seq      (m_seq),
    .status     (status),
    .m_seq_reg  (m_seq_reg),
    .m_seq_reg2 (m_seq_reg2)
  );

  imp_200 #(.CHIP_LEN(4)) u_imp (
    .clk        (sclk),
    .reset      (imp_rst_n),
    .m_seq_reg2 (imp_in),
    .out_imp    (out_imp)
  );

  always #5 sclk = ~sclk;

  task automatic step();
    @(posedge sclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [69:0] obs, input logic [69:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_values();
    chk("rst_status", 70'(status), 70'h3f);
    chk("rst_m_seq", 70'(m_seq), 70'h1);
    chk("rst_reg", m_seq_reg, 70'h0);
    chk("rst_reg2", m_seq_reg2, 70'h0);
    chk("rst_out_imp", 70'(out_imp), 70'h0);
  endtask

  // Runs from reset release for 504 edges: two imp frames of 63*4 cycles
  // and eight m-sequence periods.
  task automatic run_seq();
    logic [69:0] exp_reg;
    logic [62:0] fval;
    int          idx;
    int          runs;
    seen = '0;
    for (int c = 0; c <= 504; c++) begin
      if (c > 0) step();
      if (c <= 62) begin
        chk("state", 70'(status), 70'(exp_state[c]));
        chk("chip", 70'(m_seq), 70'(exp_chip[c]));
        chk("state_nonzero", 70'(status != 6'd0), 70'h1);
        chk("state_unique", 70'(seen[status]), 70'h0);
        seen[status] = 1'b1;
        chk("reg2_before_wrap", m_seq_reg2, 70'h0);
        if (c < 6) chk("first_ones", 70'(m_seq), 70'h1);
        if (c == 6) chk("seventh_zero", 70'(m_seq), 70'h0);
      end
      if (c > 0 && c % 63 == 0) begin
        chk("wrap_status", 70'(status), 70'h3f);
        chk("wrap_reg2", m_seq_reg2, {7'b0, exp_frame});
        chk("wrap_reg_eq_reg2", 70'(m_seq_reg[62:0]), 70'(m_seq_reg2[62:0]));
        for (int j = 0; j < 70; j++) begin
          idx = c - 1 - j;
          exp_reg[j] = (idx >= 0) ? exp_chip[idx % 63] : 1'b0;
        end
        chk("wrap_reg_full", m_seq_reg, exp_reg);
      end
      if (c == 63) begin
        chk("reg2_popcount", 70'($countones(m_seq_reg2[62:0])), 70'd32);
        chk("reg2_upper_zero", 70'(m_seq_reg2[69:63]), 70'h0);
        runs = 0;
        for (int i = 0; i <= 57; i++) begin
          if (m_seq_reg2[i +: 6] == 6'b111111) runs++;
        end
        chk("reg2_six_run", 70'(runs), 70'd1);
      end
      if (c > 63 && c % 63 == 30) chk("reg2_hold", m_seq_reg2, {7'b0, exp_frame});
      if (c > 0) begin
        fval = ((c - 1) / 252 == 0) ? one63 : ones63;
        idx  = 62 - ((c - 1) / 4) % 63;
        chk("out_imp", 70'(out_imp), 70'(fval[idx]));
      end
      // Mid-frame input change: must not show until the second frame.
      if (c == 100) imp_in = {7'b0, ones63};
    end
  endtask

  initial begin
    logic [5:0] st;
    ones63 = '1;
    one63  = 63'h1;
    st = 6'b111111;
    for (int i = 0; i < 63; i++) begin
      exp_state[i] = st;
      exp_chip[i]  = st[5];
      exp_frame[62 - i] = st[5];
      st = {st[4:0], st[5] ^ st[4]};
    end
    exp_state[63] = st;

    rst_n     = 1'b0;
    imp_rst_n = 1'b0;
    imp_in    = {7'b0, one63};
    for (int i = 0; i < 10; i++) step();
    chk_reset_values();
    rst_n     = 1'b1;
    imp_rst_n = 1'b1;
    run_seq();

    // Reset in the middle of a period and of a frame.
    for (int i = 0; i < 30; i++) step();
    rst_n     = 1'b0;
    imp_rst_n = 1'b0;
    imp_in    = {7'b0, one63};
    step();
    chk_reset_values();
    rst_n     = 1'b1;
    imp_rst_n = 1'b1;
    run_seq();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
